// File: rtl/pixel_upsampler.sv
// -----------------------------------------------------------------------------
// pixel_upsampler
//
// Nearest-neighbour frame upsampler. Reads a low-resolution frame (one pixel
// per address, raster order) from a synchronous BRAM and streams the
// full-resolution frame out over a valid/ready handshake. Each low-res pixel
// becomes a SCALE x SCALE block. One low-res row is fetched into a line buffer
// and then replayed for SCALE output rows.
//
// Optional feature macro: UPSAMPLE_CHECKSUM_EN
//   defined   -> o_checksum is a 16-bit wrapping sum of every accepted pixel,
//                cleared when a frame request is accepted.
//   undefined -> o_checksum is tied to zero and no adder exists.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   i_start      frame request, only sampled while idle
//   o_src_addr   low-res BRAM read address (16 bit)
//   i_src_data   BRAM read data, valid one cycle after o_src_addr
//   o_pix_out    full-res pixel
//   o_pix_valid  o_pix_out valid
//   i_pix_ready  downstream accepts the pixel
//   o_pix_eol    current pixel is the last column of its row
//   o_pix_last   current pixel is the last pixel of the frame
//   o_busy       frame in progress
//   o_done       one-cycle pulse after the final pixel is accepted
//   o_checksum   running pixel sum (see feature macro above)
// -----------------------------------------------------------------------------
module pixel_upsampler #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_HEIGHT = 160,
  parameter int IMG_WIDTH  = 240,
  parameter int SCALE      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic [15:0]           o_src_addr,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  output logic [DATA_WIDTH-1:0] o_pix_out,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic                  o_pix_eol,
  output logic                  o_pix_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_checksum
);

  localparam int LW   = IMG_WIDTH / SCALE;
  localparam int LH   = IMG_HEIGHT / SCALE;
  localparam int LC_W = (LW > 1) ? $clog2(LW) : 1;
  localparam int LR_W = (LH > 1) ? $clog2(LH) : 1;
  localparam int S_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FK_W = $clog2(LW + 1);

  // Flags for the very first pixel of a replayed row (position 0,0,0); only
  // non-zero in degenerate geometries where a row is a single output pixel.
  localparam bit FIRST_EOL = (LW == 1) && (SCALE == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [FK_W-1:0]       r_fill_k;   // FILL cycle index 0..LW
  logic [LR_W-1:0]       r_lr;       // low-res row
  logic [LC_W-1:0]       r_lc;       // low-res column
  logic [S_W-1:0]        r_sc;       // sub-column inside a block
  logic [S_W-1:0]        r_sr;       // sub-row inside a block
  logic [15:0]           r_src_addr;
  logic [DATA_WIDTH-1:0] r_pix_out;
  logic                  r_pix_valid;
  logic                  r_pix_eol;
  logic                  r_pix_last;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_line_buf [LW];

  logic                  w_hs;
  logic                  w_sc_wrap;
  logic                  w_lc_wrap;
  logic                  w_sr_wrap;
  logic                  w_row_end;
  logic                  w_last_row;
  logic [S_W-1:0]        w_sc_nxt;
  logic [LC_W-1:0]       w_lc_nxt;
  logic [S_W-1:0]        w_sr_nxt;
  logic                  w_eol_nxt;
  logic                  w_last_nxt;
  logic [LC_W-1:0]       w_cap_idx;
  logic [DATA_WIDTH-1:0] w_first_pix;

  assign w_hs       = r_pix_valid && i_pix_ready;
  assign w_sc_wrap  = (r_sc == S_W'(SCALE - 1));
  assign w_lc_wrap  = (r_lc == LC_W'(LW - 1));
  assign w_sr_wrap  = (r_sr == S_W'(SCALE - 1));
  assign w_row_end  = w_sc_wrap && w_lc_wrap && w_sr_wrap;
  assign w_last_row = (r_lr == LR_W'(LH - 1));

  // Position after the current handshake: sub-col, then low-col, then sub-row.
  assign w_sc_nxt = w_sc_wrap ? '0 : r_sc + S_W'(1);
  assign w_lc_nxt = !w_sc_wrap ? r_lc : (w_lc_wrap ? '0 : r_lc + LC_W'(1));
  assign w_sr_nxt = !(w_sc_wrap && w_lc_wrap) ? r_sr
                  : (w_sr_wrap ? '0 : r_sr + S_W'(1));

  assign w_eol_nxt  = (w_lc_nxt == LC_W'(LW - 1)) && (w_sc_nxt == S_W'(SCALE - 1));
  assign w_last_nxt = w_eol_nxt && (w_sr_nxt == S_W'(SCALE - 1)) && w_last_row;

  // Data arriving in FILL cycle k belongs to the address issued in cycle k-1.
  assign w_cap_idx = LC_W'(r_fill_k - FK_W'(1));

  // Entry LW-1 is written on the same edge that enters EMIT, so a one-entry
  // buffer must take the first pixel straight from the BRAM.
  assign w_first_pix = (LW == 1) ? i_src_data : r_line_buf[0];

  // NOTE: the line buffer has no reset; every entry is rewritten before it is
  // read, and leaving it out of reset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL && r_fill_k != '0) begin
      r_line_buf[w_cap_idx] <= i_src_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fill_k    <= '0;
      r_lr        <= '0;
      r_lc        <= '0;
      r_sc        <= '0;
      r_sr        <= '0;
      r_src_addr  <= '0;
      r_pix_out   <= '0;
      r_pix_valid <= 1'b0;
      r_pix_eol   <= 1'b0;
      r_pix_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_FILL;
            r_busy     <= 1'b1;
            r_lr       <= '0;
            r_fill_k   <= '0;
            r_src_addr <= '0;
          end
        end

        S_FILL: begin
          r_fill_k <= r_fill_k + FK_W'(1);
          if (r_fill_k < FK_W'(LW - 1)) begin
            r_src_addr <= r_src_addr + 16'd1;
          end
          if (r_fill_k == FK_W'(LW)) begin
            r_state     <= S_EMIT;
            r_sc        <= '0;
            r_lc        <= '0;
            r_sr        <= '0;
            r_pix_valid <= 1'b1;
            r_pix_out   <= w_first_pix;
            r_pix_eol   <= FIRST_EOL;
            r_pix_last  <= FIRST_EOL && w_last_row;
          end
        end

        S_EMIT: begin
          // Without a handshake everything holds, which keeps the output
          // stable under backpressure.
          if (w_hs) begin
            if (w_row_end) begin
              r_pix_valid <= 1'b0;
              r_pix_eol   <= 1'b0;
              r_pix_last  <= 1'b0;
              if (w_last_row) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // Low-res rows are contiguous, so the next row starts one
                // past the last address issued.
                r_state    <= S_FILL;
                r_lr       <= r_lr + LR_W'(1);
                r_fill_k   <= '0;
                r_src_addr <= r_src_addr + 16'd1;
              end
            end else begin
              r_sc       <= w_sc_nxt;
              r_lc       <= w_lc_nxt;
              r_sr       <= w_sr_nxt;
              r_pix_out  <= r_line_buf[w_lc_nxt];
              r_pix_eol  <= w_eol_nxt;
              r_pix_last <= w_last_nxt;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UPSAMPLE_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + 16'(r_pix_out);
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_src_addr  = r_src_addr;
  assign o_pix_out   = r_pix_out;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_eol   = r_pix_eol;
  assign o_pix_last  = r_pix_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/pixel_upsampler.md
# pixel_upsampler

Decompression-side counterpart to the compression downsampler. Reads a low-resolution frame (one byte per pixel, raster order) from a synchronous BRAM and emits the full-resolution frame as a raster pixel stream with valid/ready handshake. Each low-res pixel is replicated into a SCALE x SCALE block (nearest-neighbour). A one-row line buffer lets each low-res row be fetched once and replayed for SCALE output rows.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_HEIGHT, 160, full-res rows
- IMG_WIDTH, 240, full-res columns
- SCALE, 4, block edge; power of two; must divide IMG_HEIGHT and IMG_WIDTH
- Derived: LW = IMG_WIDTH/SCALE (60), LH = IMG_HEIGHT/SCALE (40); LW*LH <= 65536

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request; sampled only in IDLE
- src_addr  out  16  low-res BRAM read address
- src_data  in  DATA_WIDTH  BRAM read data, valid one cycle after src_addr
- pix_out  out  DATA_WIDTH  full-res pixel
- pix_valid  out  1  pix_out valid
- pix_ready  in  1  downstream accepts pixel
- pix_eol  out  1  pix_out is last column (x = IMG_WIDTH-1)
- pix_last  out  1  pix_out is final pixel of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final pixel accepted
- checksum  out  16  running pixel sum (see Configuration)

## Operation
- States: IDLE, FILL, EMIT, DONE.
- IDLE: start=1 at an edge -> FILL, busy=1, low-row counter lr=0, src_addr=0. start in any other state is ignored.
- FILL: src_addr = lr*LW + k for k = 0..LW-1 on consecutive cycles; src_data captured into line_buf[k] one cycle later. After capturing entry LW-1 -> EMIT with sub-col, low-col and sub-row counters at 0.
- EMIT: pix_valid=1; pix_out = line_buf[low-col]. Handshake occurs when pix_valid && pix_ready; only then does the position advance: sub-col 0..SCALE-1, then low-col 0..LW-1, then sub-row 0..SCALE-1.
- End of EMIT, i.e. handshake of sub-row SCALE-1, low-col LW-1, sub-col SCALE-1:
  - lr < LH-1 -> lr+1, FILL.
  - lr = LH-1 -> DONE.
- DONE: done=1, busy=0, pix_valid=0 for one cycle -> IDLE.
- Output pixel (y,x) equals low-res pixel (y/SCALE, x/SCALE). The frame is IMG_HEIGHT*IMG_WIDTH = 38400 pixels.
- pix_eol is high when full-res column = IMG_WIDTH-1. pix_last is high on the last pixel of the frame. Both are qualified by pix_valid.
- Reset mid-operation: frame is abandoned; all state returns to reset values; no done pulse.

## Timing
- Reset values: src_addr=0, pix_out=0, pix_valid=0, pix_eol=0, pix_last=0, busy=0, done=0, checksum=0, state IDLE.
- FILL takes LW+1 cycles (61): LW address cycles plus one capture cycle.
- EMIT with pix_ready held high takes SCALE*IMG_WIDTH cycles (960) per low-res row.
- Frame with pix_ready held high: done asserts LH*(LW+1+SCALE*IMG_WIDTH) = 40840 cycles after the start-accept edge.
- While pix_valid && !pix_ready: pix_out, pix_eol and pix_last are held stable and counters are frozen.
- pix_valid is low throughout FILL. The stream has bubbles between low-res rows; downstream must not assume continuity.
- src_addr holds its last value outside FILL.

## Configuration
- UPSAMPLE_CHECKSUM_EN defined:
  - checksum is a 16-bit wrapping sum of every handshaken pix_out.
  - It is cleared on the start-accept edge.
  - It is final and stable from the done pulse until the next start.
- UPSAMPLE_CHECKSUM_EN undefined: checksum is tied to 0 and no adder is generated.

## Test plan
- Reset: assert rst mid-clock with no clk edge -> every output at its listed reset value immediately.
- Ramp frame, pix_ready=1: low-res (r,c) = (r*60+c)&0xFF -> pixel (y,x) = ((y/4)*60 + x/4)&0xFF for all 38400 pixels; pix_eol every 240th pixel; pix_last only on pixel 38400; done 40840 cycles after start.
- Backpressure, pix_ready random 50%: pixel sequence identical to the ramp case; pix_out, pix_eol and pix_last unchanged across every stalled cycle; done still pulses exactly once.
- start pulsed during FILL and EMIT: ignored, only one frame produced. start one cycle after done: new frame begins with src_addr=0.
- rst asserted after the 1000th handshake: outputs return to reset values and no done pulse. A following start yields a complete, correct 38400-pixel frame.
- Checksum, all low-res pixels 0x01 with UPSAMPLE_CHECKSUM_EN defined: checksum = 38400 = 0x9600 at done. Without the macro: checksum = 0 throughout.
